// File: rtl/bus8085_mem_responder.sv
// Bus-slave for an 8085-style CPU bus: memory array plus small I/O register file,
// programmable READY wait states, preload port and sticky protocol-error flag.
module bus8085_mem_responder #(
  parameter int MEM_DEPTH   = 256,
  parameter int IO_PORTS    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ALE,
  input  logic       S1,
  input  logic       S0,
  input  logic       IOMn,
  input  logic       RDn,
  input  logic       WRn,
  input  logic [7:0] ADD,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       READY,
  output logic       io_wr_stb,
  output logic [7:0] io_wr_addr,
  output logic [7:0] io_wr_data,
  input  logic       ld_en,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IW = (IO_PORTS > 1) ? $clog2(IO_PORTS) : 1;
  localparam int unsigned MD  = MEM_DEPTH;
  localparam int unsigned NIO = IO_PORTS;
  localparam logic [2:0]  WS  = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  stat_q, stat_d;
  logic        iom_q, iom_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        stb_q, stb_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic [7:0]  io_q [IO_PORTS];
  logic [7:0]  io_d [IO_PORTS];
  logic [7:0]  mem_q [MEM_DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] bus_midx, ld_midx;
  logic [IW-1:0] io_idx;
  logic          io_hit;
  logic [7:0]    rd_val;

  always_comb begin
    bus_midx = AW'(32'(addr_q) % MD);
    ld_midx  = AW'(32'(ld_addr) % MD);
    io_idx   = IW'(addr_q);
    io_hit   = (32'(addr_q) < NIO);
    if (!iom_q)      rd_val = mem_q[bus_midx];
    else if (io_hit) rd_val = io_q[io_idx];
    else             rd_val = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      stat_q     <= '0;
      iom_q      <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      stb_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      io_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      stat_q     <= stat_d;
      iom_q      <= iom_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      stb_q      <= stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      io_q       <= io_d;
    end
  end

  // Memory is deliberately outside reset; gating with rst makes a reset abort any pending write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    stat_d     = stat_q;
    iom_d      = iom_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    stb_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    io_d       = io_q;
    mem_we     = 1'b0;
    mem_waddr  = ld_midx;
    mem_wdata  = ld_data;
    if (ALE) begin
      // Any ALE restarts the cycle, including from the middle of another one.
      addr_d    = ADD;
      stat_d    = {S1, S0};
      iom_d     = IOMn;
      cnt_d     = WS;
      data_oe_d = 1'b0;
      state_d   = ST_LATCH;
    end else begin
      unique case (state_q)
        ST_IDLE: mem_we = ld_en;
        ST_LATCH, ST_WAIT: begin
          if (stat_q == 2'b00)  state_d = ST_IDLE;
          else if (cnt_q == '0) state_d = stat_q[1] ? ST_READ : ST_WRITE;
          else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = ST_WAIT;
          end
        end
        ST_READ: begin
          if (!WRn) begin
            err_d     = 1'b1;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (!data_oe_q) begin
            if (!RDn) begin
              data_out_d = rd_val;
              data_oe_d  = 1'b1;
            end
          end else if (RDn) begin
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!RDn) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (!WRn) begin
            state_d = ST_DONE;
            if (!iom_q) begin
              mem_we    = 1'b1;
              mem_waddr = bus_midx;
              mem_wdata = DATA_IN;
            end else if (io_hit) begin
              io_d[io_idx] = DATA_IN;
              stb_d        = 1'b1;
              wr_addr_d    = addr_q;
              wr_data_d    = DATA_IN;
            end
          end
        end
        ST_DONE: begin
          if (!RDn) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (WRn) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    READY = 1'b1;
    if ((state_q == ST_LATCH || state_q == ST_WAIT) && stat_q != 2'b00 && cnt_q != '0)
      READY = 1'b0;
    DATA_OUT   = data_out_q;
    DATA_OE    = data_oe_q;
    io_wr_stb  = stb_q;
    io_wr_addr = wr_addr_q;
    io_wr_data = wr_data_q;
    bus_err    = err_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_bus8085_mem_responder.sv
// Bench for bus8085_mem_responder: transaction-level memory/I-O model, fixed vector table,
// random transactions, and hand sequences for wait states, errors, aborts and reset.
module tb_bus8085_mem_responder;

  logic       clk = 1'b0;
  logic       rst, ALE, S1, S0, IOMn, RDn, WRn, ld_en;
  logic [7:0] ADD, DATA_IN, ld_addr, ld_data;

  logic [7:0] DATA_OUT, io_wr_addr, io_wr_data;
  logic       DATA_OE, READY, io_wr_stb, bus_err;
  logic [2:0] state;

  logic [7:0] dout_z, wa_z, wd_z, dout_t, wa_t, wd_t;
  logic       oe_z, rdy_z, stb_z, err_z, oe_t, rdy_t, stb_t, err_t;
  logic [2:0] st_z, st_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [256];
  logic [7:0] io_m  [4];

  always #5 clk = ~clk;

  bus8085_mem_responder #(.MEM_DEPTH(256), .IO_PORTS(4), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .ALE(ALE), .S1(S1), .S0(S0), .IOMn(IOMn), .RDn(RDn), .WRn(WRn),
    .ADD(ADD), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .READY(READY),
    .io_wr_stb(io_wr_stb), .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .bus_err(bus_err), .state(state));

  bus8085_mem_responder #(.MEM_DEPTH(256), .IO_PORTS(4), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .ALE(ALE), .S1(S1), .S0(S0), .IOMn(IOMn), .RDn(RDn), .WRn(WRn),
    .ADD(ADD), .DATA_IN(DATA_IN), .DATA_OUT(dout_z), .DATA_OE(oe_z), .READY(rdy_z),
    .io_wr_stb(stb_z), .io_wr_addr(wa_z), .io_wr_data(wd_z),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .bus_err(err_z), .state(st_z));

  bus8085_mem_responder #(.MEM_DEPTH(256), .IO_PORTS(4), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst), .ALE(ALE), .S1(S1), .S0(S0), .IOMn(IOMn), .RDn(RDn), .WRn(WRn),
    .ADD(ADD), .DATA_IN(DATA_IN), .DATA_OUT(dout_t), .DATA_OE(oe_t), .READY(rdy_t),
    .io_wr_stb(stb_t), .io_wr_addr(wa_t), .io_wr_data(wd_t),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .bus_err(err_t), .state(st_t));

  typedef struct {
    logic [1:0] kind;   // 0 mem read, 1 mem write, 2 io read, 3 io write
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    int         exp_stb;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic iom, input logic [7:0] a, input logic fetch,
                          output logic [7:0] d, output int rlow);
    logic got;
    got  = 1'b0;
    rlow = 0;
    d    = '0;
    ALE = 1'b1; ADD = a; S1 = 1'b1; S0 = fetch; IOMn = iom; RDn = 1'b1; WRn = 1'b1;
    tick();
    if (!READY) rlow++;
    ALE = 1'b0; ADD = ~a; RDn = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (!READY) rlow++;
      if (DATA_OE) begin
        got = 1'b1;
        d   = DATA_OUT;
      end
    end
    if (!got) chk("rd_timeout", 32'd0, 32'd1);
    else begin
      tick();
      chk("rd_oe_hold", 32'({DATA_OE, DATA_OUT}), 32'({1'b1, d}));
    end
    RDn = 1'b1;
    tick();
    chk("rd_oe_drop", 32'(DATA_OE), 32'd0);
  endtask

  task automatic bus_write(input logic iom, input logic [7:0] a, input logic [7:0] dat,
                           output int nstb, output logic [7:0] sa, output logic [7:0] sd);
    nstb = 0;
    sa   = '0;
    sd   = '0;
    ALE = 1'b1; ADD = a; S1 = 1'b0; S0 = 1'b1; IOMn = iom; RDn = 1'b1; WRn = 1'b1;
    tick();
    ALE = 1'b0; ADD = ~a; WRn = 1'b0; DATA_IN = dat;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (io_wr_stb) begin
        nstb++;
        sa = io_wr_addr;
        sd = io_wr_data;
      end
      // Changed data while WRn stays low exposes any second commit.
      if (i == 3) DATA_IN = ~dat;
    end
    WRn = 1'b1;
    tick();
    chk("wr_idle", 32'(state), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, sa, sd, ex, a, dat;
    logic [1:0] kind;
    logic       iom;
    int         rlow, nstb;
    int         low_z, low_m, low_t, f_z, f_m, f_t;
    logic [7:0] d_z, d_m, d_t;

    tbl[0]  = '{2'd1, 8'h20, 8'h3C, 8'h00, 0};
    tbl[1]  = '{2'd0, 8'h20, 8'h00, 8'h3C, 0};
    tbl[2]  = '{2'd0, 8'h10, 8'h00, 8'hA5, 0};
    tbl[3]  = '{2'd3, 8'h02, 8'h77, 8'h00, 1};
    tbl[4]  = '{2'd2, 8'h02, 8'h00, 8'h77, 0};
    tbl[5]  = '{2'd2, 8'h09, 8'h00, 8'hFF, 0};
    tbl[6]  = '{2'd3, 8'h09, 8'h55, 8'h00, 0};
    tbl[7]  = '{2'd2, 8'h09, 8'h00, 8'hFF, 0};
    tbl[8]  = '{2'd2, 8'h01, 8'h00, 8'h00, 0};
    tbl[9]  = '{2'd1, 8'hFF, 8'h5A, 8'h00, 0};
    tbl[10] = '{2'd0, 8'hFF, 8'h00, 8'h5A, 0};
    tbl[11] = '{2'd1, 8'h20, 8'hC3, 8'h00, 0};
    tbl[12] = '{2'd0, 8'h20, 8'h00, 8'hC3, 0};
    tbl[13] = '{2'd3, 8'h03, 8'hA1, 8'h00, 1};
    tbl[14] = '{2'd2, 8'h03, 8'h00, 8'hA1, 0};

    rst = 1'b0; ALE = 1'b0; S1 = 1'b0; S0 = 1'b0; IOMn = 1'b0; RDn = 1'b1; WRn = 1'b1;
    ADD = '0; DATA_IN = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    chk("rst_data_out", 32'(DATA_OUT), 32'd0);
    chk("rst_data_oe", 32'(DATA_OE), 32'd0);
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_stb", 32'(io_wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(io_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(io_wr_data), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) io_m[i] = '0;

    for (int i = 0; i < 256; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = 8'($urandom);
      mem_m[i] = ld_data;
      tick();
    end
    ld_addr = 8'h10; ld_data = 8'hA5; mem_m[8'h10] = 8'hA5;
    tick();
    ld_en = 1'b0;

    // Same read presented to WAIT_STATES = 0, 1, 3 instances in parallel.
    low_z = 0; low_m = 0; low_t = 0; f_z = -1; f_m = -1; f_t = -1;
    d_z = '0; d_m = '0; d_t = '0;
    ALE = 1'b1; ADD = 8'h10; S1 = 1'b1; S0 = 1'b0; IOMn = 1'b0; RDn = 1'b1; WRn = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin
        ALE = 1'b0; ADD = 8'hEF; RDn = 1'b0;
      end
      if (k > 0) tick();
      if (!rdy_z) low_z++;
      if (!READY) low_m++;
      if (!rdy_t) low_t++;
      if (oe_z && f_z < 0) begin f_z = k; d_z = dout_z; end
      if (DATA_OE && f_m < 0) begin f_m = k; d_m = DATA_OUT; end
      if (oe_t && f_t < 0) begin f_t = k; d_t = dout_t; end
    end
    chk("ws0_ready_low", 32'(low_z), 32'd0);
    chk("ws1_ready_low", 32'(low_m), 32'd1);
    chk("ws3_ready_low", 32'(low_t), 32'd3);
    chk("ws0_first_oe", 32'(f_z), 32'd2);
    chk("ws1_first_oe", 32'(f_m), 32'd3);
    chk("ws3_first_oe", 32'(f_t), 32'd5);
    chk("ws0_data", 32'(d_z), 32'hA5);
    chk("ws1_data", 32'(d_m), 32'hA5);
    chk("ws3_data", 32'(d_t), 32'hA5);
    RDn = 1'b1;
    tick();
    chk("ws_oe_drop", 32'({oe_z, DATA_OE, oe_t}), 32'd0);

    for (int i = 0; i < 15; i++) begin
      iom = tbl[i].kind[1];
      if (!tbl[i].kind[0]) begin
        bus_read(iom, tbl[i].addr, 1'b0, d, rlow);
        chk($sformatf("tbl%0d_rd", i), 32'(d), 32'(tbl[i].exp));
        chk($sformatf("tbl%0d_ready_low", i), 32'(rlow), 32'd1);
      end else begin
        bus_write(iom, tbl[i].addr, tbl[i].data, nstb, sa, sd);
        chk($sformatf("tbl%0d_stb_count", i), 32'(nstb), 32'(tbl[i].exp_stb));
        if (tbl[i].exp_stb == 1) begin
          chk($sformatf("tbl%0d_stb_addr", i), 32'(sa), 32'(tbl[i].addr));
          chk($sformatf("tbl%0d_stb_data", i), 32'(sd), 32'(tbl[i].data));
        end
        if (!iom) mem_m[tbl[i].addr] = tbl[i].data;
        else if (tbl[i].addr < 8'd4) io_m[tbl[i].addr] = tbl[i].data;
      end
    end

    for (int n = 0; n < 60; n++) begin
      kind = 2'($urandom_range(0, 3));
      iom  = kind[1];
      a    = iom ? 8'($urandom_range(0, 7)) : 8'($urandom);
      dat  = 8'($urandom);
      if (!kind[0]) begin
        bus_read(iom, a, iom ? 1'b0 : 1'($urandom), d, rlow);
        if (!iom)          ex = mem_m[a];
        else if (a < 8'd4) ex = io_m[a];
        else               ex = 8'hFF;
        chk($sformatf("rnd%0d_rd_%0h", n, a), 32'(d), 32'(ex));
      end else begin
        bus_write(iom, a, dat, nstb, sa, sd);
        if (iom && a < 8'd4) begin
          io_m[a] = dat;
          chk($sformatf("rnd%0d_stb", n), 32'({nstb[7:0], sa, sd}), 32'({8'd1, a, dat}));
        end else begin
          if (!iom) mem_m[a] = dat;
          chk($sformatf("rnd%0d_nostb", n), 32'(nstb), 32'd0);
        end
      end
    end

    // Preload requests during an active cycle must be ignored.
    ld_en = 1'b1; ld_addr = 8'h22; ld_data = ~mem_m[8'h22];
    ALE = 1'b1; ADD = 8'h22; S1 = 1'b1; S0 = 1'b0; IOMn = 1'b0; RDn = 1'b1; WRn = 1'b1;
    tick();
    ALE = 1'b0; RDn = 1'b0;
    tick(); tick();
    ld_en = 1'b0;
    bus_read(1'b0, 8'h22, 1'b0, d, rlow);
    chk("ld_ignored", 32'(d), 32'(mem_m[8'h22]));

    // Second ALE in a write cycle's wait state aborts it and starts a read.
    ALE = 1'b1; ADD = 8'h33; S1 = 1'b0; S0 = 1'b1; IOMn = 1'b0; DATA_IN = ~mem_m[8'h33];
    tick();
    ALE = 1'b0; WRn = 1'b0;
    tick();
    ALE = 1'b1; S1 = 1'b1; S0 = 1'b0; WRn = 1'b1;
    tick();
    chk("abort_relatch_state", 32'(state), 32'd1);
    ALE = 1'b0; RDn = 1'b0;
    f_m = -1;
    for (int i = 0; i < 20 && f_m < 0; i++) begin
      tick();
      if (DATA_OE) begin f_m = i; d = DATA_OUT; end
    end
    chk("abort_read_done", 32'(f_m >= 0), 32'd1);
    chk("abort_no_write", 32'(d), 32'(mem_m[8'h33]));
    RDn = 1'b1;
    tick();

    ALE = 1'b1; ADD = 8'h55; S1 = 1'b0; S0 = 1'b0; IOMn = 1'b0;
    tick();
    chk("halt_latch", 32'(state), 32'd1);
    ALE = 1'b0;
    tick();
    chk("halt_idle", 32'({state, io_wr_stb, bus_err}), 32'd0);

    chk("err_clear_before", 32'(bus_err), 32'd0);
    ALE = 1'b1; ADD = 8'h40; S1 = 1'b0; S0 = 1'b1; IOMn = 1'b0; DATA_IN = ~mem_m[8'h40];
    tick();
    ALE = 1'b0; RDn = 1'b0;
    tick(); tick(); tick(); tick();
    RDn = 1'b1;
    tick();
    chk("err_rd_in_write", 32'(bus_err), 32'd1);
    chk("err_rd_in_write_idle", 32'(state), 32'd0);
    bus_read(1'b0, 8'h40, 1'b0, d, rlow);
    chk("err_rd_mem_unchanged", 32'(d), 32'(mem_m[8'h40]));
    chk("err_sticky", 32'(bus_err), 32'd1);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) io_m[i] = '0;
    chk("err_cleared_by_rst", 32'(bus_err), 32'd0);
    ALE = 1'b1; ADD = 8'h41; S1 = 1'b0; S0 = 1'b1; IOMn = 1'b0; DATA_IN = ~mem_m[8'h41];
    tick();
    ALE = 1'b0; RDn = 1'b0; WRn = 1'b0;
    tick(); tick(); tick(); tick();
    RDn = 1'b1; WRn = 1'b1;
    tick();
    chk("err_both_low", 32'(bus_err), 32'd1);
    bus_read(1'b0, 8'h41, 1'b0, d, rlow);
    chk("err_both_mem_unchanged", 32'(d), 32'(mem_m[8'h41]));

    ALE = 1'b1; ADD = 8'h10; S1 = 1'b1; S0 = 1'b0; IOMn = 1'b0;
    tick();
    ALE = 1'b0; RDn = 1'b0;
    tick(); tick(); tick();
    chk("mid_oe_up", 32'(DATA_OE), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_oe", 32'(DATA_OE), 32'd0);
    chk("mid_rst_ready", 32'(READY), 32'd1);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_misc", 32'({DATA_OUT, bus_err, io_wr_stb}), 32'd0);
    rst = 1'b1; RDn = 1'b1;
    tick();
    bus_read(1'b0, 8'h10, 1'b0, d, rlow);
    chk("mid_rst_mem_intact", 32'(d), 32'(mem_m[8'h10]));
    bus_read(1'b1, 8'h02, 1'b0, d, rlow);
    chk("mid_rst_io_cleared", 32'(d), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
